// File: rtl/vec_rf_sequencer.sv
// Command sequencer for the 4x512-bit vector register file, vector memory port and vector ALU.
// Optional watchdog on the memory/ALU wait states is enabled with `define VSEQ_TIMEOUT_EN.
module vec_rf_sequencer #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 512
`ifdef VSEQ_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [1:0]        cmd_reg,
  input  logic [ADDR_W-1:0] cmd_addr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] rf_load_data,
  output logic              rf_load,
  output logic [1:0]        rf_load_addr,
  output logic              rf_store,
  output logic [1:0]        rf_store_addr,
  output logic              rf_read,
  output logic              rf_write_enable,
  output logic              rf_set,
  output logic              alu_start,
  input  logic              alu_done,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [3:0] {
    S_IDLE, S_LD_MEM, S_LD_WR, S_ST_RD, S_ST_MEM,
    S_EX_RD, S_EX_ALU, S_EX_WB, S_SET_P, S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [1:0]        reg_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] load_buf;
  logic              alu_first;
  logic              run;
  logic              in_wait;
  logic              wd_expire;

  assign run     = !reset;
  assign in_wait = (state == S_LD_MEM) || (state == S_ST_MEM) || (state == S_EX_ALU);

`ifdef VSEQ_TIMEOUT_EN
  localparam int TW_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int TW     = (TW_RAW < 8) ? 8 : TW_RAW;

  logic [TW-1:0] wd_cnt;
  logic          wait_ok;
  logic          err_q;

  assign wait_ok   = ((state == S_LD_MEM || state == S_ST_MEM) && mem_ack) ||
                     ((state == S_EX_ALU) && alu_done);
  assign wd_expire = in_wait && (wd_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Counter restarts on every state change, so entry into a wait state starts from zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state_nxt != state) wd_cnt <= '0;
      else if (in_wait)       wd_cnt <= wd_cnt + TW'(1);
      if (state == S_IDLE)               err_q <= 1'b0;
      else if (wd_expire && !wait_ok)    err_q <= 1'b1;
    end
  end

  assign err = done && err_q;
`else
  assign wd_expire = 1'b0;
  assign err       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      reg_q     <= '0;
      addr_q    <= '0;
      load_buf  <= '0;
      alu_first <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && cmd_valid) begin
        reg_q  <= cmd_reg;
        addr_q <= cmd_addr;
      end
      if (state == S_LD_MEM && mem_ack) load_buf <= mem_rdata;
      alu_first <= (state_nxt == S_EX_ALU) && (state != S_EX_ALU);
    end
  end

  // Success (ack/done) takes priority over a watchdog expiry in the same cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:
        if (cmd_valid) begin
          case (cmd_op)
            2'b00:   state_nxt = S_LD_MEM;
            2'b01:   state_nxt = S_ST_RD;
            2'b10:   state_nxt = S_EX_RD;
            default: state_nxt = S_SET_P;
          endcase
        end
      S_LD_MEM: if (mem_ack) state_nxt = S_LD_WR;
                else if (wd_expire) state_nxt = S_DONE;
      S_LD_WR:  state_nxt = S_DONE;
      S_ST_RD:  state_nxt = S_ST_MEM;
      S_ST_MEM: if (mem_ack || wd_expire) state_nxt = S_DONE;
      S_EX_RD:  state_nxt = S_EX_ALU;
      S_EX_ALU: if (alu_done) state_nxt = S_EX_WB;
                else if (wd_expire) state_nxt = S_DONE;
      S_EX_WB:  state_nxt = S_DONE;
      S_SET_P:  state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Strobes are gated by reset so an abort never leaks a strobe on the reset cycle.
  assign busy            = run && (state != S_IDLE);
  assign cmd_ready       = !busy;
  assign mem_req         = run && (state == S_LD_MEM || state == S_ST_MEM);
  assign mem_we          = run && (state == S_ST_MEM);
  assign mem_addr        = mem_req ? addr_q : '0;
  assign rf_load         = run && (state == S_LD_WR);
  assign rf_load_addr    = rf_load ? reg_q : 2'b00;
  assign rf_load_data    = load_buf;
  assign rf_store        = run && (state == S_ST_RD);
  assign rf_store_addr   = rf_store ? reg_q : 2'b00;
  assign rf_read         = run && (state == S_EX_RD);
  assign alu_start       = run && (state == S_EX_ALU) && alu_first;
  assign rf_write_enable = run && (state == S_EX_WB);
  assign rf_set          = run && (state == S_SET_P);
  assign done            = run && (state == S_DONE);

endmodule

// File: tb/tb_vec_rf_sequencer.sv
// Scoreboard bench for vec_rf_sequencer: stimulus pushes expected events, a negedge monitor pops them.
// Build with `define VSEQ_TIMEOUT_EN to also run the watchdog case (TIMEOUT_CYCLES=8).
module tb_vec_rf_sequencer;
  localparam int AW = 16;
  localparam int DW = 512;
  localparam int EV_MREQ = 0, EV_LD = 1, EV_ST = 2, EV_RD = 3, EV_GO = 4,
                 EV_WB = 5, EV_SET = 6, EV_DONE = 7;

  typedef struct {
    int          kind;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic        f;
  } ev_t;

  ev_t sbq[$];
  int  tests_run = 0;
  int  tests_failed = 0;
  bit  mon_en = 0;
  logic mreq_prev = 1'b0;

  logic clk = 1'b0;
  logic reset, cmd_valid, mem_ack, alu_done;
  logic [1:0] cmd_op, cmd_reg;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] mem_rdata;
  logic cmd_ready, mem_req, mem_we, rf_load, rf_store, rf_read, rf_write_enable;
  logic rf_set, alu_start, busy, done, err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] rf_load_data;
  logic [1:0] rf_load_addr, rf_store_addr;

  logic [DW-1:0] pat_ab, pat_2, pat_3;

  always #5 clk = ~clk;

  vec_rf_sequencer #(
    .ADDR_W(AW), .DATA_W(DW)
`ifdef VSEQ_TIMEOUT_EN
    , .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_reg(cmd_reg), .cmd_addr(cmd_addr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .rf_load_data(rf_load_data), .rf_load(rf_load),
    .rf_load_addr(rf_load_addr), .rf_store(rf_store), .rf_store_addr(rf_store_addr),
    .rf_read(rf_read), .rf_write_enable(rf_write_enable), .rf_set(rf_set),
    .alu_start(alu_start), .alu_done(alu_done), .busy(busy), .done(done), .err(err)
  );

  function automatic void chk(string name, logic [DW-1:0] got, logic [DW-1:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endfunction

  function automatic void fail(string name);
    tests_run++;
    tests_failed++;
    $display("FAIL %s: bound expired, got no event, expected one", name);
  endfunction

  function automatic void push(int k, logic [AW-1:0] a, logic [DW-1:0] d, logic f);
    ev_t e;
    e.kind = k; e.a = a; e.d = d; e.f = f;
    sbq.push_back(e);
  endfunction

  function automatic void pop_cmp(int k, logic [AW-1:0] a, logic [DW-1:0] d, logic f);
    ev_t e;
    tests_run++;
    if (sbq.size() == 0) begin
      tests_failed++;
      $display("FAIL sb_unexpected: got event kind=%0d a=%0h f=%0b, expected none", k, a, f);
    end else begin
      e = sbq.pop_front();
      if (e.kind != k || e.a !== a || e.d !== d || e.f !== f) begin
        tests_failed++;
        $display("FAIL sb_event: got kind=%0d a=%0h f=%0b d=%0h, expected kind=%0d a=%0h f=%0b d=%0h",
                 k, a, f, d, e.kind, e.a, e.f, e.d);
      end
    end
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      chk("one_rf_strobe", DW'(int'(rf_load) + int'(rf_store) + int'(rf_read) +
                               int'(rf_write_enable) + int'(rf_set)) <= 1, 1);
      chk("ready_only_idle", cmd_ready, !busy);
      if (mem_req && !mreq_prev) pop_cmp(EV_MREQ, mem_addr, '0, mem_we);
      if (rf_load)         pop_cmp(EV_LD, AW'(rf_load_addr), rf_load_data, 1'b0);
      if (rf_store)        pop_cmp(EV_ST, AW'(rf_store_addr), '0, 1'b0);
      if (rf_read)         pop_cmp(EV_RD, '0, '0, 1'b0);
      if (alu_start)       pop_cmp(EV_GO, '0, '0, 1'b0);
      if (rf_write_enable) pop_cmp(EV_WB, '0, '0, 1'b0);
      if (rf_set)          pop_cmp(EV_SET, '0, '0, 1'b0);
      if (done)            pop_cmp(EV_DONE, '0, '0, err);
    end
    mreq_prev = mem_req;
  end

  task automatic issue(logic [1:0] op, logic [1:0] r, logic [AW-1:0] a);
    int g = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_reg = r; cmd_addr = a;
    while (!cmd_ready && g < 100) begin @(negedge clk); g++; end
    if (g >= 100) fail("issue_accept");
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_op = '0; cmd_reg = '0; cmd_addr = '0;
  endtask

  task automatic mem_txn(int lat, logic [DW-1:0] rd, logic exp_we, logic [AW-1:0] exp_addr);
    int g = 0;
    int n;
    bit we_ok;
    @(negedge clk);
    while (!mem_req && g < 50) begin @(negedge clk); g++; end
    if (!mem_req) fail("mem_req_wait");
    else begin
      chk("mem_addr", mem_addr, exp_addr);
      n = 1;
      we_ok = (mem_we === exp_we);
      repeat (lat) begin
        @(negedge clk);
        if (mem_req) n++;
        if (mem_we !== exp_we) we_ok = 0;
      end
      mem_ack = 1'b1; mem_rdata = rd;
      @(posedge clk); #1;
      mem_ack = 1'b0; mem_rdata = '0;
      @(negedge clk);
      chk("mem_we_hold", we_ok, 1);
      chk("mem_req_len", n, lat + 1);
      chk("mem_req_drop", mem_req, 0);
    end
  endtask

  task automatic alu_txn(int lat);
    int g = 0;
    @(negedge clk);
    while (!alu_start && g < 50) begin @(negedge clk); g++; end
    if (!alu_start) fail("alu_start_wait");
    else begin
      repeat (lat) @(negedge clk);
      alu_done = 1'b1;
      @(posedge clk); #1;
      alu_done = 1'b0;
      @(negedge clk);
      chk("ex_wb_cycle", rf_write_enable, 1);
      @(negedge clk);
      chk("ex_done_cycle", done, 1);
    end
  endtask

  task automatic wait_done();
    int g = 0;
    @(negedge clk);
    while (!done && g < 100) begin @(negedge clk); g++; end
    if (!done) fail("wait_done");
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    pat_ab = {64{8'hAB}};
    pat_2  = {16{32'h1234_5678}};
    pat_3  = {8{64'hDEAD_BEEF_0F0F_F0F0}};
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_reg = '0; cmd_addr = '0;
    mem_ack = 1'b0; mem_rdata = '0; alu_done = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_load_data", rf_load_data, '0);
    chk("rst_done_err", {done, err}, 0);
    mon_en = 1;

    // LOAD reg 2 @0x0040, ack on the 5th request cycle
    push(EV_MREQ, 16'h0040, '0, 1'b0);
    push(EV_LD, 16'd2, pat_ab, 1'b0);
    push(EV_DONE, '0, '0, 1'b0);
    issue(2'b00, 2'd2, 16'h0040);
    mem_txn(4, pat_ab, 1'b0, 16'h0040);
    chk("ld_wr_cycle", rf_load, 1);
    @(negedge clk);
    chk("ld_done_cycle", {done, err}, 2'b10);

    // STORE reg 3 @0x0100: store strobe precedes the write request
    push(EV_ST, 16'd3, '0, 1'b0);
    push(EV_MREQ, 16'h0100, '0, 1'b1);
    push(EV_DONE, '0, '0, 1'b0);
    issue(2'b01, 2'd3, 16'h0100);
    mem_txn(2, '0, 1'b1, 16'h0100);
    chk("st_done_cycle", {done, err}, 2'b10);

    // EXEC with alu_done 6 cycles after start, then same-cycle done
    for (int k = 0; k < 2; k++) begin
      push(EV_RD, '0, '0, 1'b0);
      push(EV_GO, '0, '0, 1'b0);
      push(EV_WB, '0, '0, 1'b0);
      push(EV_DONE, '0, '0, 1'b0);
      issue(2'b10, 2'd0, '0);
      alu_txn(k == 0 ? 6 : 0);
    end

    // SET with a LOAD held pending; LOAD only accepted after SET's done
    push(EV_SET, '0, '0, 1'b0);
    push(EV_DONE, '0, '0, 1'b0);
    push(EV_MREQ, 16'h0080, '0, 1'b0);
    push(EV_LD, 16'd1, pat_2, 1'b0);
    push(EV_DONE, '0, '0, 1'b0);
    issue(2'b11, 2'd0, '0);
    chk("set_busy_ready", {busy, cmd_ready}, 2'b10);
    issue(2'b00, 2'd1, 16'h0080);
    mem_txn(1, pat_2, 1'b0, 16'h0080);
    wait_done();

    // stray handshakes while idle
    @(negedge clk);
    mem_ack = 1'b1; alu_done = 1'b1; mem_rdata = pat_3;
    @(posedge clk); #1;
    mem_ack = 1'b0; alu_done = 1'b0; mem_rdata = '0;
    @(negedge clk);
    chk("stray_idle", {busy, cmd_ready, mem_req, done}, 4'b0100);
    chk("stray_no_capture", rf_load_data, pat_2);

    // reset while in LD_MEM aborts the load
    push(EV_MREQ, 16'h0200, '0, 1'b0);
    issue(2'b00, 2'd1, 16'h0200);
    @(negedge clk);
    @(posedge clk); #1 reset = 1'b1;
    #1 chk("rst_cycle_mem_req", mem_req, 0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_abort_state", {busy, cmd_ready, mem_req, rf_load}, 4'b0100);
    repeat (3) @(negedge clk);
    push(EV_MREQ, 16'h0300, '0, 1'b0);
    push(EV_LD, 16'd0, pat_3, 1'b0);
    push(EV_DONE, '0, '0, 1'b0);
    issue(2'b00, 2'd0, 16'h0300);
    mem_txn(0, pat_3, 1'b0, 16'h0300);
    wait_done();

`ifdef VSEQ_TIMEOUT_EN
    // LOAD with no ack: watchdog ends it after 8 request cycles with err
    begin
      int n = 0;
      push(EV_MREQ, 16'h0400, '0, 1'b0);
      push(EV_DONE, '0, '0, 1'b1);
      issue(2'b00, 2'd1, 16'h0400);
      @(negedge clk);
      while (mem_req && n < 40) begin n++; @(negedge clk); end
      chk("to_req_len", n, 8);
      chk("to_done_err", {done, err, rf_load}, 3'b110);
    end
`endif

    repeat (3) @(negedge clk);
    chk("sb_empty", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
